fpu_ss_prd_arbiter: RTL and testbench

- Shares one `fpu_ss_predecoder` instance between `NumReq` requesters, e.g. the core X-interface offload port and a replay/debug port.
- Per-requester flow: valid/ready request handshake, arbitration, instruction word registered into the predecoder, predecoder response registered, then returned on a per-requester valid/ready response channel.
- Sits between the requesters and the predecoder inside the FPU subsystem.
- At most one lookup is in flight at any time.

---
 rtl/fpu_ss_prd_arbiter.sv | 146 ++++++++++++++
 tb/tb_fpu_ss_prd_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_ss_prd_arbiter.sv
// fpu_ss_prd_arbiter: shares one predecoder between NumReq requesters.
// Only one lookup is in flight at a time: request handshake -> LOOKUP -> RESP.
// Build option: FPU_SS_PRD_ARB_RR_EN defined selects round-robin arbitration;
// left undefined, the lowest-index valid requester always wins.

package fpu_ss_pkg;
    typedef struct packed {
        logic [31:0] q_instr_data;
    } acc_prd_req_t;

    typedef struct packed {
        logic       p_accept;
        logic [1:0] p_writeback;
        logic       p_is_mem_op;
        logic [2:0] p_use_rs;
    } acc_prd_rsp_t;
endpackage

// state  | meaning
// IDLE   | waiting for a request; winner gets q_ready_o combinationally
// LOOKUP | instruction register drives the predecoder; capture its answer
// RESP   | p_valid_o[gnt_q] held with rsp_q until the granted requester takes it
module fpu_ss_prd_arbiter #(
    parameter int NumReq = 2,
    parameter int IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NumReq-1:0]                     q_valid_i,
    output logic [NumReq-1:0]                     q_ready_o,
    input  fpu_ss_pkg::acc_prd_req_t [NumReq-1:0] q_req_i,
    output logic [NumReq-1:0]                     p_valid_o,
    input  logic [NumReq-1:0]                     p_ready_i,
    output fpu_ss_pkg::acc_prd_rsp_t              p_rsp_o,
    output fpu_ss_pkg::acc_prd_req_t              prd_req_o,
    input  fpu_ss_pkg::acc_prd_rsp_t              prd_rsp_i
);
    localparam int SumW = IdxW + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [31:0]              instr_q;
    fpu_ss_pkg::acc_prd_rsp_t rsp_q;
    logic [IdxW-1:0]          gnt_q;
    logic [IdxW-1:0]          ptr_q;
    logic [IdxW-1:0]          win_idx;
    logic                     win_valid;
    logic                     q_hs;
    logic [SumW-1:0]          cand_sum;
    logic [IdxW-1:0]          cand;

`ifdef FPU_SS_PRD_ARB_RR_EN
    logic [IdxW-1:0] ptr_nxt;

    assign ptr_nxt = (win_idx == IdxW'(NumReq - 1)) ? '0 : win_idx + IdxW'(1);

    // Priority pointer moves just past the requester that was granted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else if (q_hs) begin
            ptr_q <= ptr_nxt;
        end
    end
`else
    // Fixed priority: scan always starts at requester 0.
    assign ptr_q = '0;
`endif

    // Winner: first valid requester scanning upward from ptr_q, wrapping at NumReq.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand_sum  = '0;
        cand      = '0;
        for (int i = 0; i < NumReq; i++) begin
            cand_sum = {1'b0, ptr_q} + SumW'(i);
            if (cand_sum >= SumW'(NumReq)) begin
                cand_sum = cand_sum - SumW'(NumReq);
            end
            cand = cand_sum[IdxW-1:0];
            if (!win_valid && q_valid_i[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign q_hs = (state_q == IDLE) && win_valid;

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        q_ready_o = '0;
        p_valid_o = '0;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    q_ready_o[win_idx] = 1'b1;
                    state_d            = LOOKUP;
                end
            end
            LOOKUP: begin
                state_d = RESP;
            end
            RESP: begin
                p_valid_o[gnt_q] = 1'b1;
                if (p_ready_i[gnt_q]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, instruction, grant and response registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            instr_q <= '0;
            gnt_q   <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            if (q_hs) begin
                instr_q <= q_req_i[win_idx].q_instr_data;
                gnt_q   <= win_idx;
            end
            if (state_q == LOOKUP) begin
                rsp_q <= prd_rsp_i;
            end
        end
    end

    // rsp_q only changes in LOOKUP, so the payload is stable for all of RESP.
    assign p_rsp_o                = rsp_q;
    assign prd_req_o.q_instr_data = instr_q;

endmodule

// File: tb/tb_fpu_ss_prd_arbiter.sv
// Bench for fpu_ss_prd_arbiter (NumReq = 2) with a behavioural predecoder stub.
module tb_fpu_ss_prd_arbiter;
    import fpu_ss_pkg::*;

    localparam int NR = 2;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [NR-1:0]   q_valid_i;
    logic [NR-1:0]   q_ready_o;
    acc_prd_req_t [NR-1:0] q_req_i;
    logic [NR-1:0]   p_valid_o;
    logic [NR-1:0]   p_ready_i;
    acc_prd_rsp_t    p_rsp_o;
    acc_prd_req_t    prd_req_o;
    acc_prd_rsp_t    prd_rsp_i;

    int errors = 0;
    int checks = 0;

    fpu_ss_prd_arbiter #(.NumReq(NR)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .q_valid_i (q_valid_i),
        .q_ready_o (q_ready_o),
        .q_req_i   (q_req_i),
        .p_valid_o (p_valid_o),
        .p_ready_i (p_ready_i),
        .p_rsp_o   (p_rsp_o),
        .prd_req_o (prd_req_o),
        .prd_rsp_i (prd_rsp_i)
    );

    always #5 clk_i = ~clk_i;

    // Predecoder stub: OP-FP (0x53) and LOAD-FP (0x07) accepted, all else rejected.
    function automatic acc_prd_rsp_t pd_model(input logic [31:0] instr);
        acc_prd_rsp_t r;
        r = '0;
        case (instr[6:0])
            7'h53: begin
                r.p_accept = 1'b1; r.p_writeback = 2'b01; r.p_use_rs = 3'b011;
            end
            7'h07: begin
                r.p_accept = 1'b1; r.p_writeback = 2'b01; r.p_is_mem_op = 1'b1; r.p_use_rs = 3'b001;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    assign prd_rsp_i = pd_model(prd_req_o.q_instr_data);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no DUT event within cycle budget", name);
    endtask

    // ---------------- scoreboard / reference model ----------------
    typedef enum int {M_IDLE, M_LOOKUP, M_RESP} mstate_t;
    typedef struct {
        int           idx;
        logic [31:0]  instr;
        acc_prd_rsp_t rsp;
    } sb_t;

    sb_t     sb[$];
    mstate_t m_state = M_IDLE;
    int      m_ptr   = 0;

    function automatic int exp_winner(input logic [NR-1:0] v, input int ptr);
        for (int i = 0; i < NR; i++) begin
            int c;
            c = (ptr + i) % NR;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    always @(negedge clk_i) begin
        int          w;
        logic [1:0]  er;
        sb_t         e;
        if (rst_i) begin
            m_state = M_IDLE;
            m_ptr   = 0;
            sb.delete();
        end else begin
            case (m_state)
                M_IDLE: begin
                    w  = exp_winner(q_valid_i, m_ptr);
                    er = (w < 0) ? 2'b00 : 2'(1 << w);
                    check("mon_q_ready_idle", 32'(q_ready_o), 32'(er));
                    check("mon_p_valid_idle", 32'(p_valid_o), 32'd0);
                    if (w >= 0) begin
                        sb.push_back('{w, q_req_i[w].q_instr_data, pd_model(q_req_i[w].q_instr_data)});
`ifdef FPU_SS_PRD_ARB_RR_EN
                        m_ptr = (w == NR - 1) ? 0 : w + 1;
`endif
                        m_state = M_LOOKUP;
                    end
                end
                M_LOOKUP: begin
                    check("mon_q_ready_lookup", 32'(q_ready_o), 32'd0);
                    check("mon_p_valid_lookup", 32'(p_valid_o), 32'd0);
                    if (sb.size() > 0)
                        check("mon_prd_req", prd_req_o.q_instr_data, sb[0].instr);
                    m_state = M_RESP;
                end
                default: begin
                    check("mon_sb_size", 32'(sb.size()), 32'd1);
                    if (sb.size() > 0) begin
                        e = sb[0];
                        check("mon_p_valid_resp", 32'(p_valid_o), 32'(1 << e.idx));
                        check("mon_p_rsp", 32'(p_rsp_o), 32'(e.rsp));
                        check("mon_q_ready_resp", 32'(q_ready_o), 32'd0);
                        if (p_ready_i[e.idx]) begin
                            void'(sb.pop_front());
                            m_state = M_IDLE;
                        end
                    end else begin
                        m_state = M_IDLE;
                    end
                end
            endcase
        end
    end

    // ---------------- helpers ----------------
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i     = 1'b1;
        q_valid_i = '0;
        p_ready_i = '0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    // Returns at the negedge of the handshake cycle; caller advances past the edge.
    task automatic wait_grant(input string name, output int g);
        g = -1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk_i);
            if ((q_ready_o & q_valid_i) != '0) begin
                g = (q_ready_o[0] & q_valid_i[0]) ? 0 : 1;
                break;
            end
            next_cycle();
        end
        if (g < 0) timeout_fail(name);
    endtask

    // Waits for p_valid_o, captures it, then advances past the response edge.
    task automatic wait_resp(input string name, output logic [1:0] pv, output acc_prd_rsp_t r);
        bit ok;
        ok = 1'b0;
        pv = '0;
        r  = '0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk_i);
            if (p_valid_o != '0) begin
                pv = p_valid_o;
                r  = p_rsp_o;
                ok = 1'b1;
                break;
            end
            next_cycle();
        end
        if (!ok) timeout_fail(name);
        next_cycle();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]  valid;
        logic [31:0] i0;
        logic [31:0] i1;
        int          exp_gnt;
        logic        exp_acc;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int           g;
        logic [1:0]   pv;
        acc_prd_rsp_t r;
        int           exp_order[4];

        vecs[0] = '{2'b01, 32'h0000_0053, 32'h0000_0000, 0, 1'b1};
        vecs[1] = '{2'b10, 32'h0000_0000, 32'hFFFF_FFFF, 1, 1'b0};
        vecs[2] = '{2'b11, 32'h0000_0007, 32'h0000_0053, 0, 1'b1};
`ifdef FPU_SS_PRD_ARB_RR_EN
        vecs[3] = '{2'b11, 32'h0000_0053, 32'h0000_0007, 1, 1'b1};
        exp_order = '{0, 1, 0, 1};
`else
        vecs[3] = '{2'b11, 32'h0000_0053, 32'h0000_0007, 0, 1'b1};
        exp_order = '{0, 0, 0, 0};
`endif
        vecs[4] = '{2'b10, 32'h0000_0000, 32'h1234_5633, 1, 1'b0};
        vecs[5] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0053, 0, 1'b0};

        rst_i     = 1'b1;
        q_valid_i = '0;
        p_ready_i = '0;
        q_req_i   = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_q_ready", 32'(q_ready_o), 32'd0);
        check("rst_p_valid", 32'(p_valid_o), 32'd0);
        check("rst_p_rsp", 32'(p_rsp_o), 32'd0);
        check("rst_prd_req", prd_req_o.q_instr_data, 32'd0);
        rst_i = 1'b0;

        // Single request, cycle-exact.
        q_valid_i = 2'b01;
        q_req_i[0].q_instr_data = 32'h0000_0053;
        p_ready_i = 2'b11;
        @(negedge clk_i);
        check("t1_q_ready_c0", 32'(q_ready_o), 32'b01);
        next_cycle();
        q_valid_i = 2'b00;
        @(negedge clk_i);
        check("t1_p_valid_c1", 32'(p_valid_o), 32'b00);
        check("t1_prd_req_c1", prd_req_o.q_instr_data, 32'h0000_0053);
        next_cycle();
        @(negedge clk_i);
        check("t1_p_valid_c2", 32'(p_valid_o), 32'b01);
        check("t1_accept_c2", 32'(p_rsp_o.p_accept), 32'd1);
        next_cycle();
        q_valid_i = 2'b01;
        @(negedge clk_i);
        check("t1_q_ready_c3", 32'(q_ready_o), 32'b01);
        next_cycle();
        q_valid_i = 2'b00;
        wait_resp("t1_drain", pv, r);

        // Table-driven transactions from a known pointer state.
        do_reset();
        p_ready_i = 2'b11;
        for (int k = 0; k < 6; k++) begin
            q_valid_i = vecs[k].valid;
            q_req_i[0].q_instr_data = vecs[k].i0;
            q_req_i[1].q_instr_data = vecs[k].i1;
            wait_grant("vec_grant_wait", g);
            check($sformatf("vec%0d_gnt", k), 32'(g), 32'(vecs[k].exp_gnt));
            next_cycle();
            q_valid_i = 2'b00;
            wait_resp("vec_resp_wait", pv, r);
            check($sformatf("vec%0d_p_valid", k), 32'(pv), 32'(1 << vecs[k].exp_gnt));
            check($sformatf("vec%0d_accept", k), 32'(r.p_accept), 32'(vecs[k].exp_acc));
            if (!vecs[k].exp_acc)
                check($sformatf("vec%0d_reject_zero", k), 32'({r.p_writeback, r.p_use_rs}), 32'd0);
        end

        // Both requesters held valid: grant order, then requester 1 after 0 drops.
        do_reset();
        p_ready_i = 2'b11;
        q_valid_i = 2'b11;
        q_req_i[0].q_instr_data = 32'h0000_0053;
        q_req_i[1].q_instr_data = 32'h0000_0007;
        for (int k = 0; k < 4; k++) begin
            wait_grant("arb_grant_wait", g);
            check($sformatf("arb_order%0d", k), 32'(g), 32'(exp_order[k]));
            next_cycle();
            wait_resp("arb_resp_wait", pv, r);
            check($sformatf("arb_route%0d", k), 32'(pv), 32'(1 << exp_order[k]));
        end
        q_valid_i = 2'b10;
        wait_grant("arb_grant_wait", g);
        check("arb_after_drop", 32'(g), 32'd1);
        next_cycle();
        q_valid_i = 2'b00;
        wait_resp("arb_resp_wait", pv, r);

        // Response backpressure on requester 1 while requester 0 waits.
        q_valid_i = 2'b10;
        q_req_i[1].q_instr_data = 32'h0000_0053;
        p_ready_i = 2'b01;
        wait_grant("bp_grant_wait", g);
        check("bp_gnt", 32'(g), 32'd1);
        next_cycle();
        q_valid_i = 2'b01;
        q_req_i[0].q_instr_data = 32'h0000_0007;
        @(negedge clk_i);
        next_cycle();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            check("bp_p_valid_hold", 32'(p_valid_o), 32'b10);
            check("bp_p_rsp_hold", 32'(p_rsp_o), 32'(pd_model(32'h0000_0053)));
            check("bp_q_ready_blocked", 32'(q_ready_o), 32'd0);
            next_cycle();
        end
        p_ready_i = 2'b11;
        @(negedge clk_i);
        check("bp_hs_p_valid", 32'(p_valid_o), 32'b10);
        check("bp_hs_q_ready", 32'(q_ready_o), 32'd0);
        next_cycle();
        @(negedge clk_i);
        check("bp_q_ready_after", 32'(q_ready_o), 32'b01);
        next_cycle();
        q_valid_i = 2'b00;
        wait_resp("bp_resp_wait", pv, r);
        check("bp_second_route", 32'(pv), 32'b01);

        // Reset during RESP: response dropped, pointer back to 0.
        do_reset();
        q_valid_i = 2'b01;
        q_req_i[0].q_instr_data = 32'h0000_0053;
        p_ready_i = 2'b00;
        wait_grant("rst_grant_wait", g);
        next_cycle();
        q_valid_i = 2'b00;
        @(negedge clk_i);
        next_cycle();
        @(negedge clk_i);
        check("rst_pre_p_valid", 32'(p_valid_o), 32'b01);
        #2;
        rst_i = 1'b1;
        #1;
        check("rst_async_p_valid", 32'(p_valid_o), 32'd0);
        check("rst_async_p_rsp", 32'(p_rsp_o), 32'd0);
        check("rst_async_prd_req", prd_req_o.q_instr_data, 32'd0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i     = 1'b0;
        q_valid_i = 2'b11;
        q_req_i[0].q_instr_data = 32'hFFFF_FFFF;
        q_req_i[1].q_instr_data = 32'h0000_0053;
        p_ready_i = 2'b11;
        wait_grant("rst_tie_wait", g);
        check("rst_tie_gnt", 32'(g), 32'd0);
        next_cycle();
        q_valid_i = 2'b00;
        wait_resp("rst_tie_resp", pv, r);
        check("rst_tie_route", 32'(pv), 32'b01);
        check("rst_tie_reject", 32'(r), 32'd0);

        repeat (3) next_cycle();
        check("end_sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
